// File: rtl/ebm_sched.sv
// ebm_sched: egress dequeue scheduler for four requesters.
// Picks one pending requester (strict priority for requester 0 when enabled,
// otherwise round-robin), issues a one-cycle grant plus metadata write toward
// the egress buffer manager, then waits for packet completion or aborts the
// grant after TIMEOUT_CYC cycles.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_sched_req[3:0]   pending-metadata level per requester
//   in_sched_md[47:0]   12-bit metadata per requester (requester i at [12i+11:12i])
//   in_sched_sp_en      strict priority for requester 0
//   in_sched_done       packet-complete pulse from the egress buffer manager
//   out_sched_gnt       one-hot dequeue pulse to the granted requester
//   out_sched_md        selected metadata, held between grants
//   out_sched_md_wr     one-cycle strobe for out_sched_md
//   out_sched_busy      grant outstanding
//   out_sched_timeout   one-cycle pulse when a grant is aborted
//   out_sched_err_cnt   saturating count of aborted grants
module ebm_sched #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_sched_req,
  input  logic [47:0] in_sched_md,
  input  logic        in_sched_sp_en,
  input  logic        in_sched_done,
  output logic [3:0]  out_sched_gnt,
  output logic [11:0] out_sched_md,
  output logic        out_sched_md_wr,
  output logic        out_sched_busy,
  output logic        out_sched_timeout,
  output logic [7:0]  out_sched_err_cnt
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned MD_W  = 12;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [MD_W-1:0]    md_q, md_d;
  logic               md_wr_q, md_wr_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               sel_found_c;
  logic               sel_sp_c;
  logic [PTR_W-1:0]   sel_idx_c;
  logic [PTR_W-1:0]   rr_idx_c;
  logic [MD_W-1:0]    sel_md_c;

  // Requester selection: strict priority for requester 0, else first set bit
  // at or above the pointer, wrapping 3 -> 0 through the 2-bit add.
  always_comb begin
    sel_found_c = 1'b0;
    sel_sp_c    = 1'b0;
    sel_idx_c   = ptr_q;
    rr_idx_c    = ptr_q;
    if (in_sched_sp_en && in_sched_req[0]) begin
      sel_found_c = 1'b1;
      sel_sp_c    = 1'b1;
      sel_idx_c   = '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        rr_idx_c = ptr_q + PTR_W'(k);
        if (!sel_found_c && in_sched_req[rr_idx_c]) begin
          sel_found_c = 1'b1;
          sel_idx_c   = rr_idx_c;
        end
      end
    end
  end

  // Metadata slice of the selected requester.
  always_comb begin
    sel_md_c = in_sched_md[0 +: MD_W];
    case (sel_idx_c)
      2'd1:    sel_md_c = in_sched_md[MD_W*1 +: MD_W];
      2'd2:    sel_md_c = in_sched_md[MD_W*2 +: MD_W];
      2'd3:    sel_md_c = in_sched_md[MD_W*3 +: MD_W];
      default: sel_md_c = in_sched_md[0 +: MD_W];
    endcase
  end

  // Next-state and next-output logic; outputs are the registered values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    md_d      = md_q;
    md_wr_d   = 1'b0;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (sel_found_c) begin
          state_d = ISSUE;
          md_d    = sel_md_c;
          gnt_d   = 4'b0001 << sel_idx_c;
          md_wr_d = 1'b1;
          busy_d  = 1'b1;
          // Strict-priority wins leave the round-robin position untouched.
          if (!sel_sp_c) begin
            ptr_d = sel_idx_c + PTR_W'(1);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion takes precedence over a same-cycle timeout.
        if (in_sched_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == TIMEOUT_CYC - 16'd1) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          if (err_q != 8'hFF) begin
            err_d = err_q + ERR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      md_q      <= '0;
      md_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      md_q      <= md_d;
      md_wr_q   <= md_wr_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign out_sched_gnt     = gnt_q;
  assign out_sched_md      = md_q;
  assign out_sched_md_wr   = md_wr_q;
  assign out_sched_busy    = busy_q;
  assign out_sched_timeout = timeout_q;
  assign out_sched_err_cnt = err_q;

endmodule

// File: doc/ebm_sched.md
EBM_SCHED -- requirements
Module: ebm_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd1024: cycles a grant may wait for packet completion before it is aborted.
REQ-002 SHALL have port clk  input  1  the single clock for the block.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_sched_req  input  4  per-requester pending-metadata level; bit i belongs to requester i.
REQ-005 SHALL have port in_sched_md  input  48  metadata for requester i on bits [12i+11:12i]; bits [7:0] carry the buffer ID.
REQ-006 SHALL have port in_sched_sp_en  input  1  when 1, requester 0 has strict priority.
REQ-007 SHALL have port in_sched_done  input  1  packet-complete pulse from the egress buffer manager (its valid_wr).
REQ-008 SHALL have port out_sched_gnt  output  4  one-hot dequeue pulse to the granted requester.
REQ-009 SHALL have port out_sched_md  output  12  selected metadata toward the egress buffer manager.
REQ-010 SHALL have port out_sched_md_wr  output  1  one-cycle write strobe for out_sched_md.
REQ-011 SHALL have port out_sched_busy  output  1  1 while a grant is outstanding.
REQ-012 SHALL have port out_sched_timeout  output  1  one-cycle pulse when a grant is aborted.
REQ-013 SHALL have port out_sched_err_cnt  output  8  count of timeouts; saturates at 255.

Function
REQ-014 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-015 SHALL, in IDLE with in_sched_req != 0, select one requester, register its 12-bit md and go to ISSUE in the same cycle; SHALL otherwise stay in IDLE.
REQ-016 SHALL, in ISSUE, drive out_sched_md_wr=1, out_sched_md=registered md and out_sched_gnt=one-hot(selected) for exactly one cycle, then go to WAIT.
- Latency: req sampled at cycle N gives md_wr and gnt at cycle N+1.
REQ-017 SHALL hold out_sched_md stable, and drive out_sched_md_wr=0 and out_sched_gnt=0, outside ISSUE.
REQ-018 SHALL drive out_sched_busy=1 in ISSUE and WAIT and 0 in IDLE.
REQ-019 SHALL select a requester as follows:
- if in_sched_sp_en=1 and in_sched_req[0]=1, requester 0 wins and the RR pointer is unchanged;
- otherwise round-robin over bits 0..3, searching upward from the 2-bit RR pointer with wrap 3->0;
- after a round-robin grant to i, the pointer becomes (i+1) mod 4.
REQ-020 SHALL clear a 16-bit wait counter on entry to WAIT and increment it each WAIT cycle.
REQ-021 SHALL, in WAIT with in_sched_done=1, go to IDLE on the next cycle.
- Next grant is issued no earlier than done+2 cycles.
REQ-022 SHALL, in WAIT with the counter equal to TIMEOUT_CYC-1 and in_sched_done=0, pulse out_sched_timeout for one cycle, increment out_sched_err_cnt unless it is 255, and go to IDLE.
REQ-023 SHALL let done win when done and the timeout condition occur in the same cycle: no timeout pulse, no count change.
REQ-024 SHALL ignore in_sched_done in IDLE and ISSUE.
REQ-025 SHALL not abort an outstanding grant when requests drop or in_sched_sp_en changes during WAIT; SHALL apply such changes only to the next selection.
REQ-026 SHALL take the selected requester from in_sched_req, and the md from in_sched_md, both sampled in the IDLE cycle.

Reset
REQ-027 SHALL, while rst=1, asynchronously force: state=IDLE, RR pointer=0, wait counter=0, out_sched_gnt=0, out_sched_md=0, out_sched_md_wr=0, out_sched_busy=0, out_sched_timeout=0, out_sched_err_cnt=0.
REQ-028 SHALL, on rst asserted mid-grant, drop the outstanding grant.
- After release, no timeout pulse or done effect results from that grant; selection restarts from pointer 0.

Verification
REQ-029 Basic grant: req=4'b0100, md[35:24]=12'h0A5, sp_en=0 -> at N+1: md_wr=1, md=12'h0A5, gnt=4'b0100; busy=1 until done; pointer=3.
REQ-030 Round-robin: req=4'b1111 held, done returned 3 cycles after each grant, sp_en=0 -> gnt sequence 0001,0010,0100,1000,0001.
REQ-031 Strict priority: sp_en=1, req=4'b1011 held -> every grant is 0001; clear req[0] -> next grants 0010,1000.
REQ-032 Timeout: TIMEOUT_CYC=16, one grant, no done -> timeout pulse exactly 16 cycles after entering WAIT; err_cnt=1; back in IDLE; 256 timeouts -> err_cnt stays 255.
REQ-033 Collision: done asserted on the cycle the counter equals TIMEOUT_CYC-1 -> no timeout pulse, err_cnt unchanged, IDLE next cycle.
REQ-034 Reset mid-WAIT: rst pulsed during WAIT with req=4'b0010 held -> all outputs 0 immediately; first grant after release is 0010 at release+2.
